// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor: operating mode and control FSM states.
package addsub_pkg;

  typedef enum logic {MODE_SUB = 1'b0, MODE_ADD = 1'b1} addsub_mode_e;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} addsub_state_e;

endpackage

// File: rtl/serial_addsub_if.sv
// Request/response bundle of the bit-serial adder/subtractor. The master issues operands
// with start; the slave answers with busy/done and the registered result.
interface serial_addsub_if #(parameter int WIDTH = 8);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             a_ns;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, a_ns,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, a_ns,
    output busy, done, s, cout, ovf
  );

endinterface

// File: rtl/serial_addsub_bit_cell.sv
// One-bit full adder/subtractor: b is inverted when a_ns=0 so that subtraction is a + ~b + cin.
module addsub_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic a_ns,
  output logic s,
  output logic cout
);

  logic b_eff;

  assign b_eff = b ^ ~a_ns;
  assign s     = a ^ b_eff ^ cin;
  assign cout  = (a & b_eff) | (cin & (a ^ b_eff));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one bit per clock, LSB first, through a single
// cell with its carry fed back through a flip-flop. start/busy/done handshake.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_addsub_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  addsub_state_e    state;
  addsub_state_e    state_nxt;
  logic             accept;
  logic             last_step;

  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry_q;
  addsub_mode_e     mode_q;

  logic             cell_s;
  logic             cell_cout;

  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;

  addsub_bit_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_q),
    .a_ns (mode_q),
    .s    (cell_s),
    .cout (cell_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bit_cnt == CNT_W'(WIDTH - 1)) begin
          last_step = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The A register doubles as the result shift register: each step consumes a_sr[0]
  // and the fresh sum bit enters at the MSB, so after WIDTH steps it holds the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      a_sr    <= '0;
      b_sr    <= '0;
      carry_q <= 1'b0;
      mode_q  <= MODE_SUB;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= last_step;
      if (accept) begin
        a_sr    <= bus.a;
        b_sr    <= bus.b;
        carry_q <= bus.cin;
        mode_q  <= addsub_mode_e'(bus.a_ns);
        bit_cnt <= '0;
      end else if (state == ST_RUN) begin
        a_sr    <= {cell_s, a_sr[WIDTH-1:1]};
        b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
        carry_q <= cell_cout;
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      // On the MSB step carry_q is the carry into the MSB, cell_cout the carry out.
      if (last_step) begin
        s_q    <= {cell_s, a_sr[WIDTH-1:1]};
        cout_q <= cell_cout;
        ovf_q  <= carry_q ^ cell_cout;
      end
    end
  end

  assign bus.busy = (state == ST_RUN);
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: directed WIDTH=8 vectors plus an exhaustive WIDTH=3 sweep.
module tb_serial_addsub;

  typedef struct {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
    int         due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;

  exp_t q8[$];
  exp_t q3[$];

  serial_addsub_if #(.WIDTH(8)) bus8 ();
  serial_addsub_if #(.WIDTH(3)) bus3 ();

  serial_addsub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_addsub #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop one expectation per done pulse and compare result and latency.
  always @(negedge clk) begin
    if (bus8.done === 1'b1) begin
      if (q8.size() == 0) begin
        check("w8_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("w8_s", 32'(bus8.s), 32'(e.s));
        check("w8_cout", 32'(bus8.cout), 32'(e.cout));
        check("w8_ovf", 32'(bus8.ovf), 32'(e.ovf));
        check("w8_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  always @(negedge clk) begin
    if (bus3.done === 1'b1) begin
      if (q3.size() == 0) begin
        check("w3_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q3.pop_front();
        check("w3_s", 32'(bus3.s), 32'(e.s));
        check("w3_cout", 32'(bus3.cout), 32'(e.cout));
        check("w3_ovf", 32'(bus3.ovf), 32'(e.ovf));
        check("w3_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Waits for the DUT to go idle, then drives one request; returns 1 ns after the accepting edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic add, input bit push, input logic [7:0] es,
                        input logic ec, input logic eo);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (bus8.busy !== 1'b0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("w8_busy_timeout", 32'd1, 32'd0);
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = cin;
    bus8.a_ns  = add;
    bus8.start = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    if (push) begin
      e.s = es; e.cout = ec; e.ovf = eo; e.due = cyc + 8;
      q8.push_back(e);
    end
  endtask

  task automatic issue3(input logic [2:0] a, input logic [2:0] b, input logic cin,
                        input logic add);
    int         guard;
    exp_t       e;
    logic [2:0] bb;
    logic [3:0] tot;
    guard = 0;
    @(negedge clk);
    while (bus3.busy !== 1'b0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("w3_busy_timeout", 32'd1, 32'd0);
    bus3.a     = a;
    bus3.b     = b;
    bus3.cin   = cin;
    bus3.a_ns  = add;
    bus3.start = 1'b1;
    @(posedge clk);
    #1;
    bus3.start = 1'b0;
    bb     = add ? b : ~b;
    tot    = {1'b0, a} + {1'b0, bb} + {3'b0, cin};
    e.s    = {5'b0, tot[2:0]};
    e.cout = tot[3];
    e.ovf  = (a[2] == bb[2]) && (tot[2] != a[2]);
    e.due  = cyc + 3;
    q3.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.a_ns = 1'b1;
    bus3.start = 1'b0; bus3.a = '0; bus3.b = '0; bus3.cin = 1'b0; bus3.a_ns = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_done", 32'(bus8.done), 32'd0);
    check("rst_s", 32'(bus8.s), 32'd0);
    check("rst_cout", 32'(bus8.cout), 32'd0);
    check("rst_ovf", 32'(bus8.ovf), 32'd0);
    rst_n = 1'b1;

    // Additions, including unsigned carry and signed overflow cases.
    issue8(8'h3C, 8'h05, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0);
    issue8(8'hFF, 8'h01, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    issue8(8'h7F, 8'h01, 1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1);
    issue8(8'h80, 8'h80, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1);
    issue8(8'h0F, 8'h10, 1'b1, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0);
    // Subtractions with cin=1.
    issue8(8'h05, 8'h07, 1'b1, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    issue8(8'h80, 8'h01, 1'b1, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    issue8(8'h10, 8'h10, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);

    // start pulses at edges 3 and 5 of a running op must be ignored.
    issue8(8'h3C, 8'h05, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0);
    bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b1; bus8.a_ns = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus8.start = 1'b1;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    @(posedge clk);
    #1 bus8.start = 1'b1;
    @(posedge clk);
    #1 bus8.start = 1'b0;

    // start held high through the done cycle: second op accepted on the next edge.
    issue8(8'h01, 8'h02, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
    bus8.start = 1'b1;
    bus8.a = 8'h0A; bus8.b = 8'h03; bus8.cin = 1'b1; bus8.a_ns = 1'b0;
    guard = 0;
    @(negedge clk);
    while (bus8.done !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("w8_done_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    begin
      exp_t e;
      e.s = 8'h07; e.cout = 1'b1; e.ovf = 1'b0; e.due = cyc + 8;
      q8.push_back(e);
    end

    // Reset in the middle of an op: aborted, outputs cleared at once, no done.
    issue8(8'h55, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus8.busy), 32'd0);
    check("abort_done", 32'(bus8.done), 32'd0);
    check("abort_s", 32'(bus8.s), 32'd0);
    check("abort_cout", 32'(bus8.cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue8(8'h12, 8'h34, 1'b0, 1'b1, 1'b1, 8'h46, 1'b0, 1'b0);

    // WIDTH=3 exhaustive sweep over a, b, cin and mode.
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 2; c++)
        for (int x = 0; x < 8; x++)
          for (int y = 0; y < 8; y++)
            issue3(3'(x), 3'(y), 1'(c), 1'(m));

    guard = 0;
    while ((q8.size() != 0 || q3.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check("w8_queue_drained", 32'(q8.size()), 32'd0);
    check("w3_queue_drained", 32'(q3.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
